// File: rtl/sram_arbiter.sv
// Arbitrates the boot loader and Z80 bridge onto one async SRAM. Write ack lands in cycle 2+WE_CYCLES and read ack in cycle RD_CYCLES+1.
// Requesters are stalled by holding their level req until the one-cycle ack; at least one IDLE cycle separates accesses.
module sram_arbiter #(
    parameter int ADDR_W    = 18,
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              booting,
    input  logic              boot_req,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [7:0]        boot_wdata,
    output logic              boot_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] sramAddress,
    inout  wire  [7:0]        sramData,
    output logic              n_sRamCS,
    output logic              n_sRamOE,
    output logic              n_sRamWE
);
    typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_ACCESS, R_DONE} state_t;

    localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_cpu_q, last_cpu_d;
    logic              owner_cpu_q, owner_cpu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              grant_boot, grant_cpu;
    logic              cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              drive_q, drive_d;
    logic              boot_ack_q, boot_ack_d, cpu_ack_q, cpu_ack_d;
    logic              busy_q, busy_d;
    logic [7:0]        rdata_q, rdata_d;

    // Boot mode locks the CPU out; otherwise a tie goes to whoever was not served last.
    always_comb begin
        grant_boot = 1'b0;
        grant_cpu  = 1'b0;
        if (state_q == IDLE) begin
            if (booting) begin
                grant_boot = boot_req;
            end else if (boot_req && cpu_req) begin
                grant_boot = last_cpu_q;
                grant_cpu  = !last_cpu_q;
            end else begin
                grant_boot = boot_req;
                grant_cpu  = cpu_req;
            end
        end
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_cpu_q  <= 1'b1;
            owner_cpu_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_cpu_q  <= last_cpu_d;
            owner_cpu_q <= owner_cpu_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_cpu_d  = last_cpu_q;
        owner_cpu_d = owner_cpu_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_boot) begin
                    state_d     = W_SETUP;
                    owner_cpu_d = 1'b0;
                    last_cpu_d  = 1'b0;
                    addr_d      = boot_addr;
                    wdata_d     = boot_wdata;
                end else if (grant_cpu) begin
                    state_d     = cpu_we ? W_SETUP : R_ACCESS;
                    cnt_d       = RD_LOAD;
                    owner_cpu_d = 1'b1;
                    last_cpu_d  = 1'b1;
                    addr_d      = cpu_addr;
                    wdata_d     = cpu_wdata;
                end
            end
            W_SETUP: begin
                state_d = W_STROBE;
                cnt_d   = WE_LOAD;
            end
            W_STROBE: begin
                if (cnt_q == 4'd0) state_d = W_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            W_HOLD:   state_d = IDLE;
            R_ACCESS: begin
                if (cnt_q == 4'd0) state_d = R_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            R_DONE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        cs_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        we_n_d     = 1'b1;
        drive_d    = 1'b0;
        boot_ack_d = 1'b0;
        cpu_ack_d  = 1'b0;
        busy_d     = (state_d != IDLE);
        rdata_d    = rdata_q;
        case (state_d)
            W_SETUP: begin
                cs_n_d  = 1'b0;
                drive_d = 1'b1;
            end
            W_STROBE: begin
                cs_n_d  = 1'b0;
                we_n_d  = 1'b0;
                drive_d = 1'b1;
            end
            W_HOLD: begin
                cs_n_d     = 1'b0;
                drive_d    = 1'b1;
                boot_ack_d = !owner_cpu_d;
                cpu_ack_d  = owner_cpu_d;
            end
            R_ACCESS: begin
                cs_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            R_DONE:  cpu_ack_d = 1'b1;
            default: ;
        endcase
        if (state_q == R_ACCESS && state_d == R_DONE) rdata_d = sramData;
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            drive_q    <= 1'b0;
            boot_ack_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            drive_q    <= drive_d;
            boot_ack_q <= boot_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
        end
    end

    assign sramData    = drive_q ? wdata_q : 8'hzz;
    assign sramAddress = addr_q;
    assign n_sRamCS    = cs_n_q;
    assign n_sRamOE    = oe_n_q;
    assign n_sRamWE    = we_n_q;
    assign boot_ack    = boot_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign busy        = busy_q;
    assign cpu_rdata   = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model plus directed and random traffic.
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int WE = 2;
    localparam int RD = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } req_t;

    logic clk100 = 1'b0;
    logic reset  = 1'b0;
    logic booting = 1'b0;
    logic boot_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] boot_addr = '0, cpu_addr = '0;
    logic [7:0] boot_wdata = 8'h00, cpu_wdata = 8'h00;
    logic boot_ack, cpu_ack, busy, n_cs, n_oe, n_we;
    logic [7:0] cpu_rdata;
    logic [AW-1:0] sram_addr;
    wire  [7:0] sram_data;

    logic c3_req = 1'b0, c3_we = 1'b0, c3_boot_req = 1'b0, c3_booting = 1'b0;
    logic [AW-1:0] c3_addr = '0, c3_boot_addr = '0;
    logic [7:0] c3_wdata = 8'h00, c3_boot_wdata = 8'h00;
    logic c3_boot_ack, c3_ack, c3_busy, c3_cs, c3_oe, c3_wen;
    logic [7:0] c3_rdata;
    logic [AW-1:0] c3_sram_addr;
    wire  [7:0] c3_data;

    logic [7:0] mem     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    logic [7:0] mem3    [0:255];

    int n_chk = 0;
    int n_fail = 0;
    req_t bq[$];
    req_t cq[$];
    int alog[$];

    sram_arbiter #(.ADDR_W(AW), .WE_CYCLES(WE), .RD_CYCLES(RD)) u_dut (
        .clk100(clk100), .reset(reset), .booting(booting),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_ack(boot_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .busy(busy),
        .sramAddress(sram_addr), .sramData(sram_data),
        .n_sRamCS(n_cs), .n_sRamOE(n_oe), .n_sRamWE(n_we)
    );

    sram_arbiter #(.ADDR_W(AW), .WE_CYCLES(3), .RD_CYCLES(3)) u_dut3 (
        .clk100(clk100), .reset(reset), .booting(c3_booting),
        .boot_req(c3_boot_req), .boot_addr(c3_boot_addr), .boot_wdata(c3_boot_wdata), .boot_ack(c3_boot_ack),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_rdata(c3_rdata), .cpu_ack(c3_ack), .busy(c3_busy),
        .sramAddress(c3_sram_addr), .sramData(c3_data),
        .n_sRamCS(c3_cs), .n_sRamOE(c3_oe), .n_sRamWE(c3_wen)
    );

    always #5 clk100 = ~clk100;

    // SRAM devices: drive on CS&OE, store while CS&WE are low.
    assign sram_data = (!n_cs && !n_oe) ? mem[sram_addr] : 8'hzz;
    assign c3_data   = (!c3_cs && !c3_oe) ? mem3[c3_sram_addr[7:0]] : 8'hzz;
    always @(negedge clk100) begin
        if (!n_cs && !n_we) mem[sram_addr] = sram_data;
        if (!c3_cs && !c3_wen) mem3[c3_sram_addr[7:0]] = c3_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        boot_req = (bq.size() != 0);
        cpu_req  = (cq.size() != 0);
        if (bq.size() != 0) begin
            boot_addr  = bq[0].addr;
            boot_wdata = bq[0].data;
        end
        if (cq.size() != 0) begin
            cpu_we    = cq[0].we;
            cpu_addr  = cq[0].addr;
            cpu_wdata = cq[0].data;
        end
    endtask

    task automatic push_boot(input logic [AW-1:0] a, input logic [7:0] d);
        req_t r;
        r.we = 1'b1; r.addr = a; r.data = d;
        bq.push_back(r);
        refresh();
    endtask

    task automatic push_cpu(input logic w, input logic [AW-1:0] a, input logic [7:0] d);
        req_t r;
        r.we = w; r.addr = a; r.data = d;
        cq.push_back(r);
        refresh();
    endtask

    // Reference model: one transaction at a time, described by kind and 1-based cycle offset.
    int m_kind = 0;       // 0 idle, 1 write, 2 read
    int m_off = 0;
    int m_len = 0;
    bit m_cpu = 1'b0;
    bit m_last_cpu = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_rdata = 8'h00;

    always @(posedge clk100 or posedge reset) begin
        if (reset) begin
            m_kind = 0; m_off = 0; m_last_cpu = 1'b1; m_addr = '0; m_rdata = 8'h00;
        end else if (m_kind != 0) begin
            m_off++;
            if (m_off > m_len) begin
                m_kind = 0;
            end else if (m_off == m_len) begin
                if (m_kind == 1) ref_mem[m_addr] = m_data;
                else m_rdata = ref_mem[m_addr];
            end
        end else begin
            if (boot_req && (booting || !cpu_req || m_last_cpu)) begin
                m_kind = 1; m_cpu = 1'b0; m_addr = boot_addr; m_data = boot_wdata;
            end else if (cpu_req && !booting) begin
                m_kind = cpu_we ? 1 : 2; m_cpu = 1'b1; m_addr = cpu_addr; m_data = cpu_wdata;
            end
            if (m_kind != 0) begin
                m_off = 1;
                m_last_cpu = m_cpu;
                m_len = (m_kind == 1) ? 2 + WE : RD + 1;
            end
        end
    end

    always @(negedge clk100) begin
        bit e_cs, e_oe, e_we, e_back, e_cack, e_busy;
        e_busy = (m_kind != 0);
        e_cs = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_back = 1'b0; e_cack = 1'b0;
        if (m_kind == 1) begin
            e_cs   = 1'b0;
            e_we   = !(m_off >= 2 && m_off <= WE + 1);
            e_back = (m_off == m_len) && !m_cpu;
            e_cack = (m_off == m_len) && m_cpu;
            check("wdata", sram_data, m_data);
        end else if (m_kind == 2) begin
            e_cs   = (m_off > RD);
            e_oe   = (m_off > RD);
            e_cack = (m_off > RD);
        end
        check("n_sRamCS", n_cs, e_cs);
        check("n_sRamOE", n_oe, e_oe);
        check("n_sRamWE", n_we, e_we);
        check("busy", busy, e_busy);
        check("boot_ack", boot_ack, e_back);
        check("cpu_ack", cpu_ack, e_cack);
        check("sramAddress", sram_addr, m_addr);
        check("cpu_rdata", cpu_rdata, m_rdata);
        check("oe_we_excl", n_oe | n_we, 1);
        if (!n_oe) check("rd_bus", sram_data, mem[sram_addr]);
        if (boot_ack) alog.push_back(0);
        if (cpu_ack) alog.push_back(1);
        if (e_back && bq.size() != 0) bq.delete(0);
        if (e_cack && cq.size() != 0) cq.delete(0);
        refresh();
    end

    always @(negedge clk100) begin
        check("x3_oe_we", c3_oe | c3_wen, 1);
        if (!c3_oe) check("x3_bus", c3_data, mem3[c3_sram_addr[7:0]]);
    end

    logic [31:0] t_busy, t_wel, t_oel, t_back, t_cack;
    logic [7:0] t_data [0:31];
    logic [7:0] t_rd   [0:31];

    task automatic step();
        @(negedge clk100);
        #1;
    endtask

    task automatic trace(input int n);
        t_busy = '0; t_wel = '0; t_oel = '0; t_back = '0; t_cack = '0;
        for (int i = 0; i < n; i++) begin
            step();
            t_busy[i] = busy; t_wel[i] = !n_we; t_oel[i] = !n_oe;
            t_back[i] = boot_ack; t_cack[i] = cpu_ack;
            t_data[i] = sram_data; t_rd[i] = cpu_rdata;
        end
    endtask

    function automatic int first1(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a, cnt_b, a1, a2, b1;
        bit found;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 256; i++) mem3[i] = 8'h00;
        mem[18'h01234] = 8'h5A;
        ref_mem[18'h01234] = 8'h5A;

        #1 reset = 1'b1;
        repeat (3) step();
        check("rst_cs", n_cs, 1);
        check("rst_oe", n_oe, 1);
        check("rst_we", n_we, 1);
        check("rst_busy", busy, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_addr", sram_addr, 0);
        reset = 1'b0;
        step();

        // Boot write: WE low two cycles, ack in cycle 4, data held after WE rises.
        booting = 1'b1;
        push_boot(18'h00000, 8'hC3);
        trace(12);
        check("t1_start", first1(t_busy), 0);
        check("t1_ack_cycle", first1(t_back) + 1, 4);
        check("t1_ack_pulses", $countones(t_back), 1);
        check("t1_we_low", $countones(t_wel), 2);
        check("t1_we_first", first1(t_wel) + 1, 2);
        check("t1_hold_data", t_data[3], 8'hC3);
        check("t1_mem0", mem[0], 8'hC3);

        // CPU read: OE low two cycles, ack in cycle 3, data retained.
        booting = 1'b0;
        push_cpu(1'b0, 18'h01234, 8'h00);
        trace(10);
        check("t2_start", first1(t_busy), 0);
        check("t2_ack_cycle", first1(t_cack) + 1, 3);
        check("t2_ack_pulses", $countones(t_cack), 1);
        check("t2_oe_low", $countones(t_oel), 2);
        check("t2_rdata_ack", t_rd[2], 8'h5A);
        check("t2_rdata_after", t_rd[9], 8'h5A);

        // Round robin with both pending: boot first, then alternate.
        alog.delete();
        for (int i = 0; i < 4; i++) begin
            bq.push_back(req_t'{we: 1'b1, addr: 18'(8'h40 + i), data: 8'(8'h10 + i)});
            cq.push_back(req_t'{we: 1'(i % 2), addr: 18'(8'h40 + i), data: 8'(8'h80 + i)});
        end
        refresh();
        for (int i = 0; i < 200 && (bq.size() != 0 || cq.size() != 0); i++) step();
        step();
        check("t3_drained", bq.size() + cq.size(), 0);
        check("t3_acks", alog.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t3_order%0d", i), (i < alog.size()) ? alog[i] : 9, i % 2);

        // Boot exclusivity: CPU locked out while booting.
        booting = 1'b1;
        push_cpu(1'b1, 18'h00020, 8'hE7);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt_a += cpu_ack;
            cnt_b += busy;
        end
        check("t4_no_cpu_ack", cnt_a, 0);
        check("t4_no_access", cnt_b, 0);
        booting = 1'b0;
        trace(8);
        check("t4_granted_next_idle", first1(t_busy), 0);
        check("t4_ack_cycle", first1(t_cack) + 1, 4);

        // Asynchronous reset in the middle of a strobe.
        booting = 1'b1;
        push_boot(18'h3FFFF, 8'h99);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = !n_we;
        end
        check("t5_strobe_seen", found, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_we", n_we, 1);
        check("t5_cs", n_cs, 1);
        check("t5_oe", n_oe, 1);
        check("t5_busy", busy, 0);
        check("t5_ack", boot_ack, 0);
        bq.delete();
        refresh();
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            cnt_a += boot_ack;
        end
        check("t5_no_ack", cnt_a, 0);
        reset = 1'b0;
        step();
        push_boot(18'h3FFFE, 8'h66);
        trace(10);
        check("t5_fresh_ack", first1(t_back) + 1, 4);
        check("t5_fresh_mem", mem[18'h3FFFE], 8'h66);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            step();
            if ($urandom_range(0, 3) == 0 && bq.size() < 3)
                bq.push_back(req_t'{we: 1'b1, addr: 18'($urandom_range(0, 255)), data: 8'($urandom)});
            if ($urandom_range(0, 2) == 0 && cq.size() < 3)
                cq.push_back(req_t'{we: 1'($urandom_range(0, 1)), addr: 18'($urandom_range(0, 255)), data: 8'($urandom)});
            if ($urandom_range(0, 39) == 0) booting = !booting;
            refresh();
        end
        booting = 1'b0;
        for (int i = 0; i < 300 && (bq.size() != 0 || cq.size() != 0); i++) step();
        check("rand_drained", bq.size() + cq.size(), 0);

        // Pitch with WE_CYCLES=RD_CYCLES=3: write then read back to back.
        step();
        c3_req = 1'b1; c3_we = 1'b1; c3_addr = 18'h00010; c3_wdata = 8'h77;
        a1 = -1; a2 = -1; b1 = -1;
        t_busy = '0;
        for (int i = 0; i < 24; i++) begin
            step();
            t_busy[i] = c3_busy;
            if (b1 < 0 && c3_busy) b1 = i;
            if (c3_ack) begin
                if (a1 < 0) begin
                    a1 = i;
                    c3_we = 1'b0;
                end else if (a2 < 0) begin
                    a2 = i;
                    c3_req = 1'b0;
                end
            end
        end
        check("t6_write_ack_cycle", a1 - b1 + 1, 5);
        check("t6_idle_gap", t_busy[a1 + 1], 0);
        check("t6_read_start", t_busy[a1 + 2], 1);
        check("t6_read_ack_gap", a2 - a1, 5);
        check("t6_rdata", c3_rdata, 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Owns the external 8-bit asynchronous SRAM (256K x 8) and sequences every CS/OE/WE cycle on it.
- Shares the SRAM between two requesters:
  - the SPI boot loader, which is write-only and streams ROM images in before the CPU runs;
  - the Z80 CPU bridge, which reads and writes.
- Sits between those two requesters and the top-level SRAM pins of Microcomputer.
- Guarantees data is still driven for one cycle after n_sRamWE rises, so write hold time is always met.

Parameters:
ADDR_W, 18, SRAM address width
WE_CYCLES, 2, clk100 cycles n_sRamWE is held low per write (legal 1..15)
RD_CYCLES, 2, clk100 cycles n_sRamOE/n_sRamCS are low before read data is sampled (legal 1..15)

Ports:
clk100  in  1  system clock (100 MHz); one clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
booting  in  1  1 = boot loader owns SRAM exclusively; CPU requests not granted
boot_req  in  1  boot write request, level, held until boot_ack
boot_addr  in  ADDR_W  boot write address
boot_wdata  in  8  boot write data
boot_ack  out  1  one-cycle pulse, write complete
cpu_req  in  1  CPU request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  read data, valid from cpu_ack cycle until next CPU read completes
cpu_ack  out  1  one-cycle pulse, access complete
busy  out  1  1 whenever state != IDLE
sramAddress  out  ADDR_W  SRAM address
sramData  inout  8  SRAM data bus; driven only during write states
n_sRamCS  out  1  chip select, active low
n_sRamOE  out  1  output enable, active low
n_sRamWE  out  1  write enable, active low

Behaviour:
- All SRAM outputs, acks, cpu_rdata and busy are registered; no combinational path from inputs to pins.
- Reset (asynchronous, immediate, also mid-cycle):
  - n_sRamCS=n_sRamOE=n_sRamWE=1, sramData=Z, sramAddress=0;
  - boot_ack=cpu_ack=0, cpu_rdata=0, busy=0, state=IDLE;
  - round-robin pointer "last" = CPU.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ACCESS, R_DONE.
- IDLE: all strobes high, sramData=Z, sramAddress holds last value.
- Grant, evaluated only in IDLE:
  - booting=1: grant boot_req; cpu_req is ignored (stays pending).
  - booting=0, one requester pending: grant it.
  - booting=0, both pending: grant the requester not equal to "last"; "last" is updated on every grant.
- On grant: latch address, write data and direction into internal registers. Requester inputs may change after ack only.
- Write, boot or cpu_we=1 (total 2+WE_CYCLES cycles, counted from the first non-IDLE cycle):
  - W_SETUP, 1 cycle: CS=0, WE=1, OE=1, address and data driven.
  - W_STROBE, WE_CYCLES cycles: WE=0, CS=0.
  - W_HOLD, 1 cycle: WE=1, CS=0, data still driven. The granted ack pulses high in this cycle.
  - Then IDLE.
- Read, cpu_we=0 (total RD_CYCLES+1 cycles):
  - R_ACCESS, RD_CYCLES cycles: CS=0, OE=0, WE=1, sramData=Z.
  - sramData is sampled into cpu_rdata on the clock edge ending the last R_ACCESS cycle.
  - R_DONE, 1 cycle: CS=1, OE=1, cpu_ack=1.
  - Then IDLE.
- IDLE always lasts at least 1 cycle between accesses (bus turnaround). A request already pending is granted on that IDLE cycle.
- Back-to-back write pitch is 3+WE_CYCLES cycles; back-to-back read pitch is RD_CYCLES+2 cycles.
- Strobe rules:
  - n_sRamOE and n_sRamWE are never low simultaneously.
  - sramData is never driven while n_sRamOE=0.
- A requester dropping req mid-cycle does not abort the cycle; the ack still pulses.
- booting rising during a CPU cycle does not abort it; it takes effect at the next IDLE.
- Internal counters are 4 bits and reload per state; no wrap-around is possible for legal parameters.
- Address is passed through unmodified (no wrap). boot_addr beyond 2^ADDR_W-1 is truncated to ADDR_W bits.

Test Plan:
1. Boot write, reset released, booting=1: boot_req with addr 0x00000, data 0xC3 ->
   - W_SETUP 1 cycle, n_sRamWE low exactly 2 cycles, data 0xC3 still driven the cycle after WE rises;
   - boot_ack a single pulse in cycle 4; SRAM model holds mem[0]=0xC3.
2. CPU read, booting=0, model mem[0x01234]=0x5A: cpu_req with cpu_we=0, cpu_addr 0x01234 ->
   - n_sRamOE low 2 cycles; cpu_ack pulse in cycle 3 with cpu_rdata=0x5A;
   - cpu_rdata stays 0x5A afterwards.
3. Round-robin, booting=0: boot_req and cpu_req held together, 4 transactions each -> grants alternate boot, CPU, boot, ... (first grant boot, since "last"=CPU after reset); no requester starves.
4. Boot exclusivity, booting=1: cpu_req held high for 20 cycles -> cpu_ack never pulses, SRAM is not accessed for the CPU. After booting=0, the CPU is granted on the next IDLE.
5. Reset mid-write, reset asserted during W_STROBE -> in the same cycle, without waiting for a clock edge:
   - n_sRamWE=1, n_sRamCS=1, sramData=Z, busy=0;
   - no ack pulse; after release, a fresh write completes normally.
6. Pitch and exclusion, back-to-back CPU write then read, WE_CYCLES=RD_CYCLES=3 ->
   - write ack in cycle 5; one IDLE cycle; read ack 4 cycles later;
   - a bench assertion shows n_sRamOE and n_sRamWE are never both low, and sramData is never driven while n_sRamOE=0.
